// File: rtl/posit_mult_lanes.sv
// -----------------------------------------------------------------------------
// posit_mult_lanes
// Multi-lane pipelined multiplier for denormalised posits. Each lane multiplies
// two (fraction, scale, sign, zero, NaR) tuples. All lanes share one
// rts/rtr/sow/eow stream handshake.
//
// The pipeline has PIPE_STAGES registered stages. Stage 1 captures the raw
// mantissa product and scale sum. Any middle stages are plain retiming
// registers. The output register captures the normalised, special-value
// canonicalised result. A one-entry skid buffer absorbs the single beat that
// can be accepted in the cycle the pipeline stalls, because rtr_o is
// registered.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   rts_i / rtr_o         upstream handshake (rtr_o registered)
//   sow_i, eow_i          window markers travelling with the beat
//   fraction_i1/2         per-lane fractions (no hidden bit), lane k at k*FW_IN
//   scale_i1/2            per-lane signed scales
//   sign/zero/NaR_i1/2    per-lane flags
//   rtr_i / rts_o         downstream handshake
//   sow_o, eow_o          markers aligned with the output beat
//   fraction_o            per-lane normalised product fraction, hidden bit removed
//   scale_o               per-lane signed product scale
//   sign_o/zero_o/NaR_o   per-lane result flags
// -----------------------------------------------------------------------------
module posit_mult_lanes #(
   parameter int POSIT_WIDTH = 16,
   parameter int POSIT_ES    = 1,
   parameter int LANES       = 4,
   parameter int PIPE_STAGES = 2,
   localparam int FW_IN  = POSIT_WIDTH-POSIT_ES-3,
   localparam int FW_OUT = 2*FW_IN+1,
   localparam int SW_IN  = $clog2(POSIT_WIDTH)+POSIT_ES+1,
   localparam int SW_OUT = SW_IN+1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rts_i,
   output logic                      rtr_o,
   input  logic                      sow_i,
   input  logic                      eow_i,
   input  logic [LANES*FW_IN-1:0]    fraction_i1,
   input  logic [LANES*FW_IN-1:0]    fraction_i2,
   input  logic [LANES*SW_IN-1:0]    scale_i1,
   input  logic [LANES*SW_IN-1:0]    scale_i2,
   input  logic [LANES-1:0]          sign_i1,
   input  logic [LANES-1:0]          sign_i2,
   input  logic [LANES-1:0]          zero_i1,
   input  logic [LANES-1:0]          zero_i2,
   input  logic [LANES-1:0]          NaR_i1,
   input  logic [LANES-1:0]          NaR_i2,
   input  logic                      rtr_i,
   output logic                      rts_o,
   output logic                      sow_o,
   output logic                      eow_o,
   output logic [LANES*FW_OUT-1:0]   fraction_o,
   output logic [LANES*SW_OUT-1:0]   scale_o,
   output logic [LANES-1:0]          sign_o,
   output logic [LANES-1:0]          zero_o,
   output logic [LANES-1:0]          NaR_o
);

   localparam int PW = 2*FW_IN+2;   // raw product width

   typedef struct packed {
      logic [LANES*FW_IN-1:0]  f1, f2;
      logic [LANES*SW_IN-1:0]  s1, s2;
      logic [LANES-1:0]        sg1, sg2, z1, z2, n1, n2;
      logic                    sow, eow;
   } in_t;

   typedef struct packed {
      logic [LANES*PW-1:0]     p;
      logic [LANES*SW_OUT-1:0] s;
      logic [LANES-1:0]        sg, z, n;
      logic                    sow, eow, vld;
   } raw_t;

   logic                      w_adv;
   logic                      w_acc;
   logic                      r_rtr;
   logic                      r_skid_vld;
   in_t                       r_skid;
   in_t                       w_in;
   in_t                       w_src;
   logic                      w_vld;
   logic [LANES*PW-1:0]       w_p;
   logic [LANES*SW_OUT-1:0]   w_s;
   raw_t                      w_raw;
   raw_t                      w_last;
   logic [LANES*FW_OUT-1:0]   w_frac;
   logic [LANES*SW_OUT-1:0]   w_scale;
   logic [LANES-1:0]          w_sign;
   logic [LANES-1:0]          w_zero;
   logic [LANES-1:0]          w_nar;
   logic                      r_vld;
   logic                      r_sow;
   logic                      r_eow;
   logic [LANES*FW_OUT-1:0]   r_frac;
   logic [LANES*SW_OUT-1:0]   r_scale;
   logic [LANES-1:0]          r_sign;
   logic [LANES-1:0]          r_zero;
   logic [LANES-1:0]          r_nar;

   // Every stage moves in lockstep; only an empty output slot or a consuming
   // sink lets the pipe advance.
   assign w_adv = rtr_i | ~r_vld;
   assign w_acc = rts_i & r_rtr;

   assign w_in = {fraction_i1, fraction_i2, scale_i1, scale_i2,
                  sign_i1, sign_i2, zero_i1, zero_i2, NaR_i1, NaR_i2,
                  sow_i, eow_i};

   // While the skid entry is full rtr_o is low, so the skid beat can never
   // collide with a live beat.
   assign w_src = r_skid_vld ? r_skid : w_in;
   assign w_vld = r_skid_vld | w_acc;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rtr      <= 1'b0;
         r_skid_vld <= 1'b0;
         r_skid     <= '0;
      end else begin
         r_rtr <= w_adv;
         if (w_adv) begin
            r_skid_vld <= 1'b0;
         end else if (w_acc) begin
            r_skid_vld <= 1'b1;
            r_skid     <= w_in;
         end
      end
   end

   // Stage 1 arithmetic: hidden-bit product and sign-extended scale sum.
   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_mul
         logic [FW_IN:0]   w_m1, w_m2;
         logic [SW_IN-1:0] w_s1, w_s2;
         assign w_m1 = {1'b1, w_src.f1[gi*FW_IN +: FW_IN]};
         assign w_m2 = {1'b1, w_src.f2[gi*FW_IN +: FW_IN]};
         assign w_s1 = w_src.s1[gi*SW_IN +: SW_IN];
         assign w_s2 = w_src.s2[gi*SW_IN +: SW_IN];
         assign w_p[gi*PW +: PW]         = PW'(w_m1) * PW'(w_m2);
         assign w_s[gi*SW_OUT +: SW_OUT] = {w_s1[SW_IN-1], w_s1} + {w_s2[SW_IN-1], w_s2};
      end
   endgenerate

   assign w_raw = {w_p, w_s,
                   w_src.sg1 ^ w_src.sg2,
                   w_src.z1 | w_src.z2,
                   w_src.n1 | w_src.n2,
                   w_src.sow & w_vld,
                   w_src.eow & w_vld,
                   w_vld};

   // Stage 1 plus any retiming stages. With a single stage the raw product
   // feeds the normaliser combinationally into the output register.
   generate
      if (PIPE_STAGES > 1) begin : g_pipe
         raw_t r_pipe [PIPE_STAGES-1];
         always_ff @(posedge clk) begin
            if (rst) begin
               for (int k = 0; k < PIPE_STAGES-1; k++) r_pipe[k] <= '0;
            end else if (w_adv) begin
               r_pipe[0] <= w_raw;
               for (int k = 1; k < PIPE_STAGES-1; k++) r_pipe[k] <= r_pipe[k-1];
            end
         end
         assign w_last = r_pipe[PIPE_STAGES-2];
      end else begin : g_nopipe
         assign w_last = w_raw;
      end
   endgenerate

   // Normalise: product of two [1,2) mantissas lies in [1,4). NaR wins over zero.
   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_norm
         logic [PW-1:0]     w_pl;
         logic [SW_OUT-1:0] w_sl;
         logic [FW_OUT-1:0] w_fn;
         logic [SW_OUT-1:0] w_sn;
         logic              w_spec;
         assign w_pl   = w_last.p[gi*PW +: PW];
         assign w_sl   = w_last.s[gi*SW_OUT +: SW_OUT];
         assign w_fn   = w_pl[PW-1] ? w_pl[PW-2:0] : {w_pl[PW-3:0], 1'b0};
         assign w_sn   = w_pl[PW-1] ? w_sl + SW_OUT'(1) : w_sl;
         assign w_spec = w_last.n[gi] | w_last.z[gi];
         assign w_nar[gi]  = w_last.n[gi];
         assign w_zero[gi] = ~w_last.n[gi] & w_last.z[gi];
         assign w_sign[gi] = ~w_spec & w_last.sg[gi];
         assign w_frac[gi*FW_OUT +: FW_OUT]  = w_spec ? '0 : w_fn;
         assign w_scale[gi*SW_OUT +: SW_OUT] = w_spec ? '0 : w_sn;
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         r_vld   <= 1'b0;
         r_sow   <= 1'b0;
         r_eow   <= 1'b0;
         r_frac  <= '0;
         r_scale <= '0;
         r_sign  <= '0;
         r_zero  <= '0;
         r_nar   <= '0;
      end else if (w_adv) begin
         r_vld   <= w_last.vld;
         r_sow   <= w_last.sow;
         r_eow   <= w_last.eow;
         r_frac  <= w_frac;
         r_scale <= w_scale;
         r_sign  <= w_sign;
         r_zero  <= w_zero;
         r_nar   <= w_nar;
      end
   end

   assign rtr_o      = r_rtr;
   assign rts_o      = r_vld;
   assign sow_o      = r_sow;
   assign eow_o      = r_eow;
   assign fraction_o = r_frac;
   assign scale_o    = r_scale;
   assign sign_o     = r_sign;
   assign zero_o     = r_zero;
   assign NaR_o      = r_nar;

endmodule
